// File: rtl/fsm_pkg.sv
// Shared constants, checker state encoding and ring-sequence helper for the
// FSM trace checker.
package fsm_pkg;

  localparam int unsigned STATES = 5;
  localparam int unsigned SW     = 3;

  typedef logic [SW-1:0] state_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCheck = 2'd1,
    StDone  = 2'd2,
    StFail  = 2'd3
  } chk_state_e;

  // Next expected ring state; wraps STATES-1 back to 0.
  function automatic state_t ring_next(state_t s, logic adv);
    if (!adv) begin
      return s;
    end
    return (s == state_t'(STATES - 1)) ? '0 : s + state_t'(1);
  endfunction

endpackage

// File: rtl/fsm_trace_checker_if.sv
// Sample bus from the FSM under test into the trace checker.
interface fsm_trace_checker_if;
  import fsm_pkg::*;

  logic          en;
  logic          adv;
  logic [SW-1:0] y;

  modport master (output en, output adv, output y);
  modport slave  (input en, input adv, input y);

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fsm_trace_checker.sv
// Checks the FSM next-state stream against the 0..STATES-1 ring, counts samples
// and per-state visits, and latches the first mismatch into a sticky verdict.
module fsm_trace_checker
  import fsm_pkg::*;
#(
  parameter int unsigned CW         = 8,
  parameter int unsigned VW         = 4,
  parameter int unsigned MAX_CYCLES = 10,
  parameter int unsigned INIT_EXP   = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  fsm_trace_checker_if.slave   smp,
  output logic [CW-1:0]        cycles,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic [SW-1:0]        err_got,
  output logic [SW-1:0]        err_exp,
  output logic [CW-1:0]        err_cycle,
  output logic [STATES*VW-1:0] visits
);

  chk_state_e    state_q, state_d;
  logic [SW-1:0] exp_q, exp_d;
  logic [CW-1:0] cycles_q, cycles_d;
  logic [SW-1:0] err_got_q, err_got_d;
  logic [SW-1:0] err_exp_q, err_exp_d;
  logic [CW-1:0] err_cycle_q, err_cycle_d;
  logic          sample_err;
  logic          sample_ok;

  // Illegal encodings are flagged even though exp_q can never hold one.
  assign sample_err = (smp.y >= SW'(STATES)) || (smp.y != exp_q);

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    cycles_d    = cycles_q;
    err_got_d   = err_got_q;
    err_exp_d   = err_exp_q;
    err_cycle_d = err_cycle_q;
    sample_ok   = 1'b0;
    if (((state_q == StIdle) || (state_q == StCheck)) && smp.en) begin
      cycles_d = cycles_q + CW'(1);
      if (sample_err) begin
        state_d     = StFail;
        err_got_d   = smp.y;
        err_exp_d   = exp_q;
        err_cycle_d = cycles_q;
      end else begin
        sample_ok = 1'b1;
        exp_d     = ring_next(exp_q, smp.adv);
        state_d   = (cycles_q == CW'(MAX_CYCLES - 1)) ? StDone : StCheck;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      exp_q       <= SW'(INIT_EXP);
      cycles_q    <= '0;
      err_got_q   <= '0;
      err_exp_q   <= '0;
      err_cycle_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      cycles_q    <= cycles_d;
      err_got_q   <= err_got_d;
      err_exp_q   <= err_exp_d;
      err_cycle_q <= err_cycle_d;
    end
  end

  for (genvar k = 0; k < STATES; k++) begin : g_visit
    sat_counter #(
      .W (VW)
    ) u_visit_cnt (
      .clk_i (clock),
      .clr_i (reset),
      .inc_i (sample_ok && (smp.y == SW'(k))),
      .cnt_o (visits[k*VW +: VW])
    );
  end

  assign cycles    = cycles_q;
  assign done      = (state_q == StDone) || (state_q == StFail);
  assign pass      = (state_q == StDone);
  assign fail      = (state_q == StFail);
  assign err_got   = err_got_q;
  assign err_exp   = err_exp_q;
  assign err_cycle = err_cycle_q;

endmodule

// File: tb/tb_fsm_trace_checker.sv
// Self-checking bench for fsm_trace_checker: table rows queued into a scoreboard,
// plus end-of-scenario checks on error capture and visit counters.
module tb_fsm_trace_checker;

  logic clock;
  logic reset;

  fsm_trace_checker_if smp  ();
  fsm_trace_checker_if smp2 ();

  logic [7:0]  cycles,  cycles2;
  logic        done,    done2;
  logic        pass,    pass2;
  logic        fail,    fail2;
  logic [2:0]  err_got, err_got2;
  logic [2:0]  err_exp, err_exp2;
  logic [7:0]  err_cycle, err_cycle2;
  logic [19:0] visits,  visits2;

  fsm_trace_checker dut (
    .clock     (clock),
    .reset     (reset),
    .smp       (smp),
    .cycles    (cycles),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .err_got   (err_got),
    .err_exp   (err_exp),
    .err_cycle (err_cycle),
    .visits    (visits)
  );

  fsm_trace_checker #(
    .MAX_CYCLES (20)
  ) dut20 (
    .clock     (clock),
    .reset     (reset),
    .smp       (smp2),
    .cycles    (cycles2),
    .done      (done2),
    .pass      (pass2),
    .fail      (fail2),
    .err_got   (err_got2),
    .err_exp   (err_exp2),
    .err_cycle (err_cycle2),
    .visits    (visits2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       adv;
    logic [2:0] y;
    logic [7:0] cyc;
    logic       done;
    logic       pass;
    logic       fail;
  } vec_t;

  typedef struct packed {
    logic [7:0] cyc;
    logic       done;
    logic       pass;
    logic       fail;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic rst, logic en, logic adv, int y, int cyc,
                              logic d, logic p, logic f);
    vec_t v;
    v.rst  = rst;
    v.en   = en;
    v.adv  = adv;
    v.y    = 3'(y);
    v.cyc  = 8'(cyc);
    v.done = d;
    v.pass = p;
    v.fail = f;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Drives one row per clock; expected outputs go through the scoreboard queue.
  task automatic run_table(input string tag);
    exp_t e;
    exp_t g;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      reset    = vecs[i].rst;
      smp.en   = vecs[i].en;
      smp.adv  = vecs[i].adv;
      smp.y    = vecs[i].y;
      smp2.en  = vecs[i].en;
      smp2.adv = vecs[i].adv;
      smp2.y   = vecs[i].y;
      sb_q.push_back('{cyc: vecs[i].cyc, done: vecs[i].done,
                       pass: vecs[i].pass, fail: vecs[i].fail});
      @(posedge clock);
      #1;
      g = '{cyc: cycles, done: done, pass: pass, fail: fail};
      e = sb_q.pop_front();
      check($sformatf("%s row %0d {cycles,done,pass,fail}", tag, i), 32'(g), 32'(e));
    end
    @(negedge clock);
    reset  = 1'b0;
    smp.en = 1'b0;
    smp2.en = 1'b0;
    vecs.delete();
  endtask

  task automatic push_good_run();
    for (int i = 0; i < 10; i++) begin
      vecs.push_back(mk(0, 1, 1, (i + 1) % 5, i + 1, i == 9, i == 9, 0));
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " err_got"},   32'(err_got),   32'd0);
    check({tag, " err_exp"},   32'(err_exp),   32'd0);
    check({tag, " err_cycle"}, 32'(err_cycle), 32'd0);
    check({tag, " visits"},    32'(visits),    32'd0);
  endtask

  initial begin
    int k;
    reset    = 1'b1;
    smp.en   = 1'b0;
    smp.adv  = 1'b0;
    smp.y    = '0;
    smp2.en  = 1'b0;
    smp2.adv = 1'b0;
    smp2.y   = '0;

    // 1: full correct ring, two laps
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    push_good_run();
    run_table("t1");
    check("t1 visits", 32'(visits), 32'h22222);

    // 2: wrong value on the second sample, then held
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 3, 2, 1, 0, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 1, 3, 2, 1, 0, 1));
    run_table("t2");
    check("t2 err_got",   32'(err_got),   32'd3);
    check("t2 err_exp",   32'(err_exp),   32'd2);
    check("t2 err_cycle", 32'(err_cycle), 32'd1);
    check("t2 visits",    32'(visits),    32'h00010);

    // 3: illegal encoding on the first sample
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 6, 1, 1, 0, 1));
    run_table("t3");
    check("t3 err_got",   32'(err_got),   32'd6);
    check("t3 err_exp",   32'(err_exp),   32'd1);
    check("t3 err_cycle", 32'(err_cycle), 32'd0);

    // 7a: reset out of FAIL, then a fresh passing run
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    run_table("t7a_rst");
    check_cleared("t7a");
    push_good_run();
    run_table("t7a_run");

    // 4: en gaps carry garbage y that must be ignored; DONE is sticky
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    k = 0;
    for (int j = 0; j < 28; j++) begin
      if (j % 3 == 0) begin
        vecs.push_back(mk(0, 1, 1, (k + 1) % 5, k + 1, k == 9, k == 9, 0));
        k++;
      end else begin
        vecs.push_back(mk(0, 0, 1, 7, k, 0, 0, 0));
      end
    end
    vecs.push_back(mk(0, 1, 1, 7, 10, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 7, 10, 1, 1, 0));
    run_table("t4");
    check("t4 visits", 32'(visits), 32'h22222);

    // 5 + 6: hold y=1 with adv=0; the MAX_CYCLES=20 instance saturates visits
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++) begin
      vecs.push_back(mk(0, 1, 0, 1, (i < 10) ? i + 1 : 10, i >= 9, i >= 9, 0));
    end
    run_table("t5");
    check("t5 visits", 32'(visits), 32'h000A0);
    check("t6 cycles", 32'(cycles2), 32'd20);
    check("t6 pass",   32'({done2, pass2, fail2}), 32'b110);
    check("t6 visits", 32'(visits2), 32'h000F0);

    // 7: reset on the fifth sample mid-run
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, 1, i + 1, i + 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0));
    run_table("t7_rst");
    check_cleared("t7");
    push_good_run();
    run_table("t7_run");
    check("t7 visits", 32'(visits), 32'h22222);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
